mult_unit: RTL and testbench

Multi-cycle 32x32 integer multiplier with HI/LO result registers for the single-cycle CPU's mult/multu/mfhi/mflo instructions. Operands come directly from register_file read ports Da/Db. The product is held in HI/LO. The selected half is driven on result, which feeds the register file write-data mux (Dw). The CPU's control stalls the PC while busy is high.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_shift_add.sv | 27 ++
 rtl/mult_unit.sv | 129 ++++++++++++
 tb/tb_mult_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multi-cycle HI/LO multiplier: state encoding and default sizes.
package mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/mult_shift_add.sv
// One combinational shift-add step: optionally add the multiplicand into the upper
// half of the accumulator, then shift {carry, accumulator} right by one bit.
module mult_shift_add
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               add_en,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   upper_sum;
    logic [2*WIDTH:0] widened;

    // Add into the upper half with one extra carry bit, then drop the LSB by shifting
    always_comb begin
        upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (add_en) begin
            upper_sum = upper_sum + {1'b0, mcand};
        end
        widened  = {upper_sum, acc[WIDTH-1:0]};
        acc_next = (2*WIDTH)'(widened >> 1);
    end

endmodule

// File: rtl/mult_unit.sv
// Multi-cycle 32x32 multiplier for mult/multu with HI/LO result registers and an
// mfhi/mflo read mux. Signed operands are reduced to magnitudes, multiplied by an
// LSB-first shift-add loop, and the sign is reapplied in a final fix-up cycle.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] Da,
    input  logic [WIDTH-1:0] Db,
    input  logic             mfhi,
    input  logic             mflo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] product;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // 0x80000000 negates to itself, which is exactly its unsigned magnitude
    assign mag_a   = (signed_op && Da[WIDTH-1]) ? -Da : Da;
    assign mag_b   = (signed_op && Db[WIDTH-1]) ? -Db : Db;
    assign product = neg ? -acc : acc;

    assign busy   = (state != IDLE);
    assign result = mfhi ? hi : (mflo ? lo : '0);

    mult_shift_add #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .add_en   (mplier[0]),
        .acc_next (acc_next)
    );

    // State register; reset aborts any multiply in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE, FIX always returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch operands, iterate the shift-add, then publish the signed product
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= signed_op & (Da[WIDTH-1] ^ Db[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: begin
                    hi   <= product[2*WIDTH-1:WIDTH];
                    lo   <= product[WIDTH-1:0];
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: a table of directed multiplies followed by
// hand-written sequences for ignored starts, back-to-back starts and async reset.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] da;
    logic [31:0] db;
    logic        mfhi;
    logic        mflo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    mult_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .Da        (da),
        .Db        (db),
        .mfhi      (mfhi),
        .mflo      (mflo),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .result    (result)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present operands with start for one edge (E0); returns #1 after E0
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        da        = a;
        db        = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after E0 until done is seen (bounded); also count cycles busy fell early
    task automatic wait_done(output int edges, output int busy_drops);
        edges      = 0;
        busy_drops = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (done !== 1'b1 && busy !== 1'b1) busy_drops++;
        end
    endtask

    initial begin
        int edges;
        int drops;

        reset     = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        da        = '0;
        db        = '0;
        mfhi      = 1'b0;
        mflo      = 1'b0;

        vecs[0] = '{32'h00000003, 32'h00000005, 1'b0, 32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
        vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000};
        vecs[6] = '{32'h00000005, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[7] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000};
        vecs[8] = '{32'h12345678, 32'h10000000, 1'b0, 32'h01234567, 32'h80000000};

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_hi", hi, 32'h0);
        check_output("reset_lo", lo, 32'h0);
        mflo = 1'b1;
        #1;
        check_output("reset_result", result, 32'h0);
        mflo = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] table-driven multiplies");
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].s);
            check_output($sformatf("v%0d_busy_after_start", i), 32'(busy), 32'd1);
            wait_done(edges, drops);
            check_output($sformatf("v%0d_latency", i), 32'(edges), 32'd33);
            check_output($sformatf("v%0d_busy_gaps", i), 32'(drops), 32'd0);
            check_output($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            check_output($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check_output($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            mflo = 1'b1;
            #1;
            check_output($sformatf("v%0d_result_lo", i), result, vecs[i].exp_lo);
            mfhi = 1'b1;
            #1;
            check_output($sformatf("v%0d_result_hi", i), result, vecs[i].exp_hi);
            mfhi = 1'b0;
            mflo = 1'b0;
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d_done_drops", i), 32'(done), 32'd0);
        end

        $display("[TB] result mux priority");
        mfhi = 1'b1;
        mflo = 1'b0;
        #1;
        check_output("mux_hi_only", result, 32'h01234567);
        mfhi = 1'b0;
        mflo = 1'b0;
        #1;
        check_output("mux_none", result, 32'h0);

        $display("[TB] start ignored while busy, operands changed mid-run");
        apply_stimulus(32'd2, 32'd3, 1'b0);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (edges == 5) begin
                mflo = 1'b1;
                #1;
                check_output("busy_lo_held", lo, 32'h80000000);
                check_output("busy_result_old", result, 32'h80000000);
                mflo = 1'b0;
            end
            if (edges == 10) begin
                start = 1'b1;
                da    = 32'd9;
                db    = 32'd9;
            end else if (edges == 11) begin
                start = 1'b0;
                da    = 32'hDEADBEEF;
                db    = 32'h0BADF00D;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        check_output("ignore_latency", 32'(edges), 32'd33);
        check_output("ignore_hi", hi, 32'h0);
        check_output("ignore_lo", lo, 32'd6);

        $display("[TB] start during done cycle");
        start = 1'b1;
        da    = 32'd9;
        db    = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("done_cycle_accepted", 32'(busy), 32'd1);
        check_output("done_single_pulse", 32'(done), 32'd0);
        wait_done(edges, drops);
        check_output("back2back_latency", 32'(edges), 32'd33);
        check_output("back2back_lo", lo, 32'd81);

        $display("[TB] asynchronous reset mid-multiply");
        apply_stimulus(32'h12345678, 32'h10000000, 1'b0);
        wait_done(edges, drops);
        check_output("pre_reset_hi", hi, 32'h01234567);
        apply_stimulus(32'h00000077, 32'h00000055, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_output("async_reset_busy", 32'(busy), 32'd0);
        check_output("async_reset_done", 32'(done), 32'd0);
        check_output("async_reset_hi", hi, 32'h0);
        check_output("async_reset_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("post_reset_idle", 32'(busy), 32'd0);
        apply_stimulus(32'd4, 32'd4, 1'b0);
        wait_done(edges, drops);
        check_output("post_reset_latency", 32'(edges), 32'd33);
        check_output("post_reset_lo", lo, 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
